// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    localparam int DATA_W = 32;
    // Entries carry the widest word index a 32-bit byte address can produce;
    // unused upper bits are always zero and drop out in synthesis.
    localparam int IDX_W  = DATA_W - 2;

    typedef enum logic {
        IDLE,
        WRITE
    } drain_state_t;

    typedef struct packed {
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } wbuf_entry_t;

    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// rtl/dmem_wbuf.sv - circular write buffer with youngest-match associative lookup
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  wbuf_entry_t              push_entry_i,
    input  logic [IDX_W-1:0]         lookup_index_i,
    output wbuf_entry_t              head_entry_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        hit_data_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t        entries_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop_i) begin
            head_d = head_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            entries_q[tail_q] <= push_entry_i;
        end
    end

    // Walk oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PTR_W-1:0] pos;
        pos        = '0;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (entries_q[pos].index == lookup_index_i)) begin
                hit_o      = 1'b1;
                hit_data_o = entries_q[pos].data;
            end
        end
    end

    assign head_entry_o = entries_q[head_q];
    assign count_o      = count_q;
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign empty_o      = (count_q == '0);

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - M-stage data memory with posted write buffer; optional DMEM_STATS_EN counters
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int WR_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    output logic              BusyM,
    output logic              OverflowM,
    output logic              ErrM
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       LoadCnt,
    output logic [31:0]       StoreCnt,
    output logic [31:0]       FwdCnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int LAT_W = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

    logic [DATA_W-1:0]  ram_q [2**ADDR_W];

    logic [ADDR_W-1:0]  word_idx;
    logic [IDX_W-1:0]   lookup_idx;
    wbuf_entry_t        push_entry;
    wbuf_entry_t        head_entry;
    logic [CNT_W-1:0]   count;
    logic               full, empty, hit;
    logic [DATA_W-1:0]  hit_data;

    logic               rd_req;
    logic               push_ok;
    logic               drain_done;
    logic               err_cond;

    drain_state_t       state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic               overflow_q, overflow_d;
    logic               err_q, err_d;

    assign word_idx   = ALUResultM[ADDR_W+1:2];
    assign lookup_idx = IDX_W'(word_idx);
    assign push_entry = '{index: lookup_idx, data: WriteDataM};

    // A simultaneous read+write is treated as a store; the load half is refused.
    assign rd_req     = MemReadM && !MemWriteM;
    assign drain_done = (state_q == WRITE) && (cnt_q == LAT_W'(WR_LAT - 1));
    assign push_ok    = MemWriteM && (!full || drain_done);
    assign err_cond   = ((MemReadM || MemWriteM) && is_misaligned(ALUResultM[1:0]))
                      || (MemReadM && MemWriteM);

    dmem_wbuf #(
        .DEPTH (DEPTH)
    ) u_wbuf (
        .clk            (clk),
        .rst            (rst),
        .push_i         (push_ok),
        .pop_i          (drain_done),
        .push_entry_i   (push_entry),
        .lookup_index_i (lookup_idx),
        .head_entry_o   (head_entry),
        .count_o        (count),
        .full_o         (full),
        .empty_o        (empty),
        .hit_o          (hit),
        .hit_data_o     (hit_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = WRITE;
                    cnt_d   = '0;
                end
            end
            WRITE: begin
                if (drain_done) begin
                    cnt_d   = '0;
                    state_d = ((count > CNT_W'(1)) || push_ok) ? WRITE : IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q || (MemWriteM && !push_ok);
        err_d      = err_q || err_cond;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
        end
    end

    // RAM is never cleared; reset only suppresses a drain write that is in flight.
    always_ff @(posedge clk) begin
        if (!rst && drain_done) begin
            ram_q[head_entry.index[ADDR_W-1:0]] <= head_entry.data;
        end
    end

    always_comb begin
        ReadDataM = '0;
        if (rd_req) begin
            ReadDataM = hit ? hit_data : ram_q[word_idx];
        end
    end

    assign BusyM     = !empty;
    assign OverflowM = overflow_q;
    assign ErrM      = err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] load_cnt_q, store_cnt_q, fwd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (rd_req) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (push_ok) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
            if (rd_req && hit) begin
                fwd_cnt_q <= fwd_cnt_q + 32'd1;
            end
        end
    end

    assign LoadCnt  = load_cnt_q;
    assign StoreCnt = store_cnt_q;
    assign FwdCnt   = fwd_cnt_q;
`endif

    logic unused_ok;
    assign unused_ok = ^{ALUResultM[31:ADDR_W+2], head_entry.index[IDX_W-1:ADDR_W]};

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemReadM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataM;
    logic        BusyM, OverflowM, ErrM;
`ifdef DMEM_STATS_EN
    logic [31:0] LoadCnt, StoreCnt, FwdCnt;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W (8),
        .DEPTH  (4),
        .WR_LAT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .BusyM      (BusyM),
        .OverflowM  (OverflowM),
        .ErrM       (ErrM)
`ifdef DMEM_STATS_EN
        ,
        .LoadCnt    (LoadCnt),
        .StoreCnt   (StoreCnt),
        .FwdCnt     (FwdCnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        rst        = 1'b0;
        MemReadM   = rd;
        MemWriteM  = wr;
        ALUResultM = a;
        WriteDataM = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 && BusyM; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
        end
        check(tag, {31'b0, BusyM}, 32'h0);
    endtask

    initial begin
        do_reset();
        check("rst_busy", {31'b0, BusyM}, 32'h0);
        check("rst_ovf",  {31'b0, OverflowM}, 32'h0);
        check("rst_err",  {31'b0, ErrM}, 32'h0);
        check("rst_rdata", ReadDataM, 32'h0);

        // Forwarding from buffer, then exact drain latency, then read from RAM.
        drive(1'b0, 1'b1, 32'h10, 32'h11);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        check("fwd_0x10", ReadDataM, 32'h11);
        check("fwd_busy", {31'b0, BusyM}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            check("drain_busy", {31'b0, BusyM}, 32'h1);
        end
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        check("drain_done_busy", {31'b0, BusyM}, 32'h0);
        check("ram_0x10", ReadDataM, 32'h11);

        // Youngest matching entry wins.
        drive(1'b0, 1'b1, 32'h20, 32'hA);
        drive(1'b0, 1'b1, 32'h20, 32'hB);
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        check("youngest_0x20", ReadDataM, 32'hB);
        wait_idle("idle_after_0x20");
        drive(1'b1, 1'b0, 32'h20, 32'h0);
        check("ram_0x20", ReadDataM, 32'hB);

        // Preload known RAM values for later tests.
        drive(1'b0, 1'b1, 32'h40, 32'h77);
        drive(1'b0, 1'b1, 32'h74, 32'hCC);
        wait_idle("idle_preload");

        // Six back-to-back stores: 5th lands on the pop edge, 6th is dropped.
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 32'h60 + 32'(4 * i), 32'(i + 1));
            check("no_ovf_yet", {31'b0, OverflowM}, 32'h0);
        end
        drive(1'b1, 1'b0, 32'h74, 32'h0);
        check("ovf_set", {31'b0, OverflowM}, 32'h1);
        check("dropped_not_fwd", ReadDataM, 32'hCC);
        drive(1'b1, 1'b0, 32'h70, 32'h0);
        check("fifth_fwd", ReadDataM, 32'h5);
        wait_idle("idle_after_burst");
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h60 + 32'(4 * i), 32'h0);
            check("burst_ram", ReadDataM, 32'(i + 1));
        end
        drive(1'b1, 1'b0, 32'h74, 32'h0);
        check("dropped_ram", ReadDataM, 32'hCC);

        // Reset during WRITE count 1 abandons the drain.
        drive(1'b0, 1'b1, 32'h40, 32'h5);
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        check("fwd_0x40", ReadDataM, 32'h5);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();
        drive(1'b1, 1'b0, 32'h40, 32'h0);
        check("abort_busy", {31'b0, BusyM}, 32'h0);
        check("abort_ram", ReadDataM, 32'h77);
        check("abort_ovf", {31'b0, OverflowM}, 32'h0);
        check("abort_err", {31'b0, ErrM}, 32'h0);

        // Misaligned load, aliasing, and simultaneous read/write.
        drive(1'b1, 1'b0, 32'h13, 32'h0);
        check("misalign_data", ReadDataM, 32'h11);
        check("misalign_err_pre", {31'b0, ErrM}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("misalign_err", {31'b0, ErrM}, 32'h1);
        check("no_read_zero", ReadDataM, 32'h0);
        drive(1'b1, 1'b0, 32'h410, 32'h0);
        check("alias_0x410", ReadDataM, 32'h11);
        do_reset();
        drive(1'b1, 1'b1, 32'h80, 32'h99);
        check("rdwr_zero", ReadDataM, 32'h0);
        drive(1'b1, 1'b0, 32'h80, 32'h0);
        check("rdwr_err", {31'b0, ErrM}, 32'h1);
        check("rdwr_store", ReadDataM, 32'h99);
        wait_idle("idle_after_rdwr");

`ifdef DMEM_STATS_EN
        do_reset();
        drive(1'b0, 1'b1, 32'h100, 32'h1);
        drive(1'b0, 1'b1, 32'h104, 32'h2);
        drive(1'b0, 1'b1, 32'h108, 32'h3);
        drive(1'b1, 1'b0, 32'h100, 32'h0);
        drive(1'b1, 1'b0, 32'h200, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        check("stat_store", StoreCnt, 32'd3);
        check("stat_load", LoadCnt, 32'd2);
        check("stat_fwd", FwdCnt, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
